// File: rtl/adc_scan_scheduler.sv
// rtl/adc_scan_scheduler.sv - periodic multi-channel ADC scan scheduler feeding a sample FIFO
module adc_scan_scheduler #(
  parameter int DIV_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr,
  input  logic [7:0]       chan_mask,
  input  logic [DIV_W-1:0] sample_div,
  output logic [2:0]       adc_addr,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [11:0]      adc_data,
  input  logic             fifo_full,
  output logic             fifo_wrreq,
  output logic [15:0]      fifo_data,
  output logic             busy,
  output logic [7:0]       drop_cnt,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, START, WAIT_DONE, WRITE} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;
  logic [7:0]       pending, pending_next;
  logic [2:0]       chan, chan_next;
  logic [2:0]       mask_first, pend_first;
  logic [11:0]      sample;
  logic [WAIT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             advance;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  assign mask_first = lowest_bit(chan_mask);
  assign pend_first = lowest_bit(pending);

  // Tick fires on the last count of each period; >= guards against sample_div shrinking mid-count.
  assign tick = enable && (tick_cnt >= sample_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    chan_next    = chan;
    timeout_hit  = 1'b0;
    advance      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (tick && chan_mask != 8'd0) begin
          chan_next    = mask_first;
          pending_next = chan_mask & ~(8'd1 << mask_first);
          state_next   = START;
        end
      end
      START: begin
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (adc_done) begin
          state_next = WRITE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          advance     = 1'b1;
        end
      end
      WRITE: begin
        advance = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Pending holds the scan's own snapshot of the mask, so live mask edits wait for the next scan.
    if (advance) begin
      if (!enable) begin
        state_next = IDLE;
      end else if (pending != 8'd0) begin
        chan_next    = pend_first;
        pending_next = pending & ~(8'd1 << pend_first);
        state_next   = START;
      end else begin
        state_next = WAIT_TICK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan       <= 3'd0;
      pending    <= 8'd0;
      sample     <= 12'd0;
      wait_cnt   <= '0;
      adc_addr   <= 3'd0;
      adc_start  <= 1'b0;
      busy       <= 1'b0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= 16'd0;
    end else begin
      chan      <= chan_next;
      pending   <= pending_next;
      adc_start <= (state_next == START);
      busy      <= (state_next inside {START, WAIT_DONE, WRITE});
      if (state_next == START) adc_addr <= chan_next;
      wait_cnt  <= (state == WAIT_DONE) ? wait_cnt + 1'b1 : '0;
      if (state == WAIT_DONE && adc_done) sample <= adc_data;
      fifo_wrreq <= (state == WRITE) && !fifo_full;
      if (state == WRITE && !fifo_full) fifo_data <= {1'b0, chan, sample};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt    <= 8'd0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else if (clr) begin
      drop_cnt    <= 8'd0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == WRITE && fifo_full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (tick && busy) overrun <= 1'b1;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb/tb_adc_scan_scheduler.sv - scoreboard bench for adc_scan_scheduler with a latency-programmable ADC model
module tb_adc_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clr;
  logic [7:0]  chan_mask;
  logic [15:0] sample_div;
  logic [2:0]  adc_addr;
  logic        adc_start;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        fifo_full;
  logic        fifo_wrreq;
  logic [15:0] fifo_data;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic        overrun;
  logic        timeout_err;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  int          adc_lat = 20;
  logic [7:0]  no_answer = 8'h00;
  logic        model_on = 1'b1;
  logic        chk_overlap = 1'b0;
  logic        outstanding = 1'b0;
  int          start_cnt = 0;
  int          wr_cnt = 0;

  adc_scan_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
    .chan_mask(chan_mask), .sample_div(sample_div),
    .adc_addr(adc_addr), .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .busy(busy), .drop_cnt(drop_cnt), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int target, input int bound);
    int n;
    n = 0;
    while (exp_q.size() > target && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'(target));
  endtask

  task automatic wait_start(input string name, input logic [2:0] addr, input int bound);
    int n;
    n = 0;
    while (!(adc_start && adc_addr == addr) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(adc_start && adc_addr == addr), 32'd1);
  endtask

  task automatic wait_scan_end(input int bound);
    int n;
    n = 0;
    while (!busy && n < bound) begin @(negedge clk); n++; end
    while (busy && n < bound) begin @(negedge clk); n++; end
    if (n >= bound) check("scan_end_bound", 32'(n), 32'(bound - 1));
  endtask

  // ADC model: answers adc_lat cycles after a start with 0xA00 + channel unless silenced
  initial begin
    int         cnt;
    logic [2:0] ch;
    cnt = 0;
    ch = 3'd0;
    adc_data = 12'd0;
    forever begin
      @(negedge clk);
      if (model_on) begin
        adc_done = 1'b0;
        if (!rst_n) begin
          cnt = 0;
        end else if (adc_start) begin
          cnt = adc_lat;
          ch = adc_addr;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0 && !no_answer[ch]) begin
            adc_done = 1'b1;
            adc_data = 12'hA00 + 12'(ch);
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every FIFO write and polices start/write pairing
  initial begin
    logic have_exp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fifo_wrreq) begin
          wr_cnt++;
          outstanding = 1'b0;
          have_exp = (exp_q.size() != 0);
          check("write_expected", 32'(have_exp), 32'd1);
          if (have_exp) check("fifo_data", 32'(fifo_data), 32'(exp_q.pop_front()));
        end
        if (adc_start) begin
          start_cnt++;
          if (chk_overlap) check("start_while_outstanding", 32'(outstanding), 32'd0);
          outstanding = 1'b1;
        end
      end else begin
        outstanding = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    clr = 1'b0;
    chan_mask = 8'h00;
    sample_div = 16'd0;
    adc_done = 1'b0;
    fifo_full = 1'b0;
    cycles(3);
    check("rst_adc_addr", 32'(adc_addr), 32'd0);
    check("rst_adc_start", 32'(adc_start), 32'd0);
    check("rst_fifo_wrreq", 32'(fifo_wrreq), 32'd0);
    check("rst_fifo_data", 32'(fifo_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Basic periodic scan: two 100-cycle periods of mask A4
    chan_mask = 8'hA4;
    sample_div = 16'd99;
    adc_lat = 20;
    chk_overlap = 1'b1;
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(16'h2A02);
      exp_q.push_back(16'h5A05);
      exp_q.push_back(16'h7A07);
    end
    enable = 1'b1;
    wait_drain("basic_drain", 0, 400);
    enable = 1'b0;
    cycles(5);
    check("basic_overrun", 32'(overrun), 32'd0);
    check("basic_timeout", 32'(timeout_err), 32'd0);
    check("basic_busy_idle", 32'(busy), 32'd0);

    // Full FIFO: every sample dropped, counter saturates, clr resets it
    chk_overlap = 1'b0;
    fifo_full = 1'b1;
    chan_mask = 8'hFF;
    sample_div = 16'd39;
    adc_lat = 2;
    enable = 1'b1;
    wait_scan_end(200);
    check("drop_after_one_scan", 32'(drop_cnt), 32'd8);
    for (int s = 1; s < 32; s++) wait_scan_end(200);
    enable = 1'b0;
    cycles(2);
    check("drop_saturated", 32'(drop_cnt), 32'd255);
    check("drop_no_overrun", 32'(overrun), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("drop_cleared", 32'(drop_cnt), 32'd0);

    // Silent channel 3: timeout after 1023 WAIT_DONE cycles, then normal service resumes
    begin
      int n;
      fifo_full = 1'b0;
      adc_lat = 20;
      no_answer = 8'h08;
      chan_mask = 8'h08;
      sample_div = 16'd1999;
      enable = 1'b1;
      wait_start("to_start_ch3", 3'd3, 2500);
      n = 0;
      while (busy && n < 3000) begin
        n++;
        @(negedge clk);
      end
      check("to_busy_cycles", 32'(n), 32'd1024);
      check("to_err_set", 32'(timeout_err), 32'd1);
      check("to_wr_none", 32'(wr_cnt), 32'd6);
      no_answer = 8'h00;
      exp_q.push_back(16'h3A03);
      wait_drain("to_resume_drain", 0, 2500);
      enable = 1'b0;
      cycles(3);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("to_err_cleared", 32'(timeout_err), 32'd0);
    end

    // Ticks every 6 cycles against a 176-cycle scan: overrun, no overlapping scans
    chk_overlap = 1'b1;
    chan_mask = 8'hFF;
    sample_div = 16'd5;
    for (int c = 0; c < 8; c++) exp_q.push_back({1'b0, 3'(c), 12'hA00 + 12'(c)});
    enable = 1'b1;
    wait_drain("ovr_seven", 1, 400);
    enable = 1'b0;
    wait_drain("ovr_last", 0, 60);
    cycles(3);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_busy_idle", 32'(busy), 32'd0);

    // Enable dropped in channel 2's conversion: channel 2 still written, channel 3 never started
    chan_mask = 8'h0F;
    sample_div = 16'd199;
    exp_q.push_back(16'h0A00);
    exp_q.push_back(16'h1A01);
    exp_q.push_back(16'h2A02);
    start_cnt = 0;
    enable = 1'b1;
    wait_start("dis_start_ch2", 3'd2, 400);
    cycles(5);
    enable = 1'b0;
    wait_drain("dis_drain", 0, 60);
    cycles(40);
    check("dis_start_count", 32'(start_cnt), 32'd3);
    check("dis_busy_idle", 32'(busy), 32'd0);

    // Asynchronous reset during WAIT_DONE, then a stale adc_done
    begin
      int wr_before;
      chan_mask = 8'h10;
      enable = 1'b1;
      wait_start("ar_start_ch4", 3'd4, 400);
      cycles(5);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_adc_addr", 32'(adc_addr), 32'd0);
      check("ar_fifo_data", 32'(fifo_data), 32'd0);
      check("ar_overrun", 32'(overrun), 32'd0);
      model_on = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wr_before = wr_cnt;
      cycles(3);
      adc_done = 1'b1;
      adc_data = 12'h555;
      @(negedge clk);
      adc_done = 1'b0;
      cycles(30);
      check("ar_stale_no_write", 32'(wr_cnt), 32'(wr_before));
      check("ar_busy_after", 32'(busy), 32'd0);
      enable = 1'b0;
    end

    cycles(2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
